// File: rtl/vga_pkg.sv
// Default 640x480@60 raster timing constants and helpers shared by the VGA timing path.
package vga_pkg;

  localparam int DEF_CLK_DIV  = 2;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_IMG_W    = 256;
  localparam int DEF_IMG_H    = 256;

  localparam int CNT_W   = 10;
  localparam int CNT_MAX = 1 << CNT_W;

  function automatic int h_total(int act, int fp, int sync, int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(int act, int fp, int sync, int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_pixel_tick_gen.sv
// Divides the system clock into a one-clk pixel tick and a registered pixel clock
// whose rising edge falls mid-pixel.
module pixel_tick_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick,
  output logic o_vga_clk
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] HALF = DW'(CLK_DIV / 2);

  logic [DW-1:0] r_div_cnt;
  logic [DW-1:0] w_cnt_next;
  logic          w_tick;
  logic          r_vga_clk;

  assign w_tick     = (r_div_cnt == LAST);
  assign w_cnt_next = w_tick ? '0 : r_div_cnt + 1'b1;

  // vga_clk is decoded from the upcoming count so it tracks div_cnt without lag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_cnt <= '0;
      r_vga_clk <= 1'b0;
    end else begin
      r_div_cnt <= w_cnt_next;
      r_vga_clk <= (w_cnt_next >= HALF);
    end
  end

  assign o_tick    = w_tick;
  assign o_vga_clk = r_vga_clk;

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: h/v counters on the pixel tick, registered sync/blank decode
// and image-window hold/x/y/frameStart for the downstream pixel stage.
module vga_timing
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H
) (
  input  logic       clk,
  input  logic       rst,
  output logic       vga_clk,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       hold,
  output logic       frameStart,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic [9:0] hcount,
  output logic [9:0] vcount
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX || CLK_DIV < 2 || (CLK_DIV % 2) != 0 ||
      IMG_W > H_ACTIVE || IMG_W > 256 || IMG_H > V_ACTIVE || IMG_H > 256) begin : g_param_err
    $error("vga_timing: illegal timing parameters");
  end

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] IMG_X  = 10'(IMG_W);
  localparam logic [9:0] IMG_Y  = 10'(IMG_H);

  logic       w_tick;
  logic [9:0] w_h_next;
  logic [9:0] w_v_next;
  logic       w_hold_next;

  logic [9:0] r_hcount;
  logic [9:0] r_vcount;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_blank_n;
  logic       r_hold;
  logic       r_frame_start;
  logic [7:0] r_x;
  logic [7:0] r_y;

  pixel_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .o_tick   (w_tick),
    .o_vga_clk(vga_clk)
  );

  always_comb begin
    w_h_next = r_hcount + 10'd1;
    w_v_next = r_vcount;
    if (r_hcount == H_LAST) begin
      w_h_next = '0;
      w_v_next = (r_vcount == V_LAST) ? '0 : r_vcount + 10'd1;
    end
  end

  assign w_hold_next = !((w_h_next < IMG_X) && (w_v_next < IMG_Y));

  // Decodes are taken from the next counter values so they land on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hcount      <= H_LAST;
      r_vcount      <= V_LAST;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_blank_n     <= 1'b0;
      r_hold        <= 1'b1;
      r_x           <= '0;
      r_y           <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_tick && (w_h_next == '0) && (w_v_next == V_ACT);
      if (w_tick) begin
        r_hcount  <= w_h_next;
        r_vcount  <= w_v_next;
        r_hsync   <= !((w_h_next >= HS_BEG) && (w_h_next < HS_END));
        r_vsync   <= !((w_v_next >= VS_BEG) && (w_v_next < VS_END));
        r_blank_n <= (w_h_next < H_ACT) && (w_v_next < V_ACT);
        r_hold    <= w_hold_next;
        r_x       <= w_hold_next ? '0 : w_h_next[7:0];
        r_y       <= w_hold_next ? '0 : w_v_next[7:0];
      end
    end
  end

  assign hcount     = r_hcount;
  assign vcount     = r_vcount;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign blank_n    = r_blank_n;
  assign hold       = r_hold;
  assign x          = r_x;
  assign y          = r_y;
  assign frameStart = r_frame_start;

endmodule
